tdm_demux8: RTL and testbench
=============================

// Module: tdm_demux8
// PURPOSE
//  Serial-to-parallel receive end of the 8:1 mux serializer path.
//  A transmitter steps the mux select 0..7 and sends one bit per beat.
//  This block is the matching 1:8 time-division demultiplexer:
//  - takes that bit stream and routes beat k to lane k;
//  - delivers the completed 8-bit word on a valid/ready output;
//  - flags framing errors.
// PARAMETERS
//  LANES      8   number of time slots/lanes per frame (>=2)
//  LSB_FIRST  1   1: slot k -> out[k] (matches mux sel=k -> in[k]);
//                 0: slot k -> out[LANES-1-k]
//  SEL_W      $clog2(LANES)  slot index width (derived, not overridden)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  in           in   1      serial data bit for current slot
//  in_valid     in   1      beat present on in/frame_start
//  in_ready     out  1      beat accepted when in_valid && in_ready
//  frame_start  in   1      marks beat as slot 0 of a new frame
//  out          out  LANES  deserialized word, stable while out_valid
//  out_valid    out  1      word available
//  out_ready    in   1      consumer takes word when out_valid && out_ready
//  sel          out  SEL_W  slot index the next accepted beat will fill
//  frame_err    out  1      one-cycle pulse on framing violation
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - state=IDLE; sel=0; shift/assembly reg=0; out=0; out_valid=0; frame_err=0.
//  - Reset mid-frame discards the partial word.
//  - Reset also discards a pending out word.
//  FSM IDLE:
//  - Accepted beat with frame_start=1 -> bit to slot 0, sel=1, go COLLECT.
//  - Accepted beat with frame_start=0 -> bit dropped, frame_err pulses next cycle, stay IDLE.
//  FSM COLLECT:
//  - Accepted beat with frame_start=0 -> bit to slot sel, sel=sel+1.
//  - Accepted beat with frame_start=1 -> partial frame discarded, frame_err pulses,
//    bit to slot 0, sel=1, stay COLLECT.
//  Frame completion:
//  - Accepting slot LANES-1 loads the full word into out.
//  - out_valid=1 on the following cycle (latency: 1 clk after last beat).
//  - sel wraps to 0, state -> IDLE.
//  - No beat, no state change (in_valid gaps are allowed anywhere in a frame).
//  Output handshake:
//  - out_valid holds, and out is stable, until out_valid && out_ready.
//  - Then out_valid drops next cycle unless a new word completes that same cycle.
//  Backpressure:
//  - in_ready = !(state==COLLECT && sel==LANES-1 && out_valid && !out_ready).
//  - Only the final beat stalls; earlier slots always accept.
//  - in_ready is combinational from registered state and out_ready.
//  Simultaneous completion and drain:
//  - Word completes while the old word is taken (out_ready=1).
//  - out takes the new word, out_valid stays 1, no bubble, no loss.
//  Other rules:
//  - frame_start on the LANES-1 beat is an error: restart rule applies, no word emitted.
//  - sel is a registered output, valid every cycle; 0 in IDLE.
//  - frame_err is registered and never asserted during or the cycle after reset.
// STRUCTURE
//  Shared package tdm_pkg:
//  - state typedef {IDLE, COLLECT};
//  - function slot_w(lanes) = $clog2(lanes);
//  - constant DEFAULT_LANES=8 (shared with the serializer-side select counter).
//  Sub-module tdm_slot_counter (SEL_W):
//  - mod-LANES counter with inc, load0, wrap outputs;
//  - same counter drives the mux select on the transmit side.
//  The assembly register, output register and FSM live in tdm_demux8.
// TESTING
//  1. Basic frame, LSB_FIRST=1, out_ready=1:
//     stimulus: frame_start on beat0; bits 1,0,1,1,0,0,1,0 on back-to-back beats.
//     required: out=8'h4D, out_valid high exactly 1 clk, 1 clk after beat7.
//  2. Gaps:
//     stimulus: same frame with in_valid low 3 cycles between beats 2 and 3.
//     required: out=8'h4D, sel holds 3 during gap.
//  3. Backpressure:
//     stimulus: out_ready=0; frame 8'hA5 then frame 8'h3C.
//     required: in_ready=0 only at second frame's beat7; out stays A5.
//     stimulus: raise out_ready.
//     required: 3C accepted, out=3C one clk later, no bit lost.
//  4. Restart mid-frame:
//     stimulus: frame_start at sel=5.
//     required: frame_err 1-clk pulse, sel=1 after, next full frame delivered correctly.
//  5. Orphan beat:
//     stimulus: IDLE beat without frame_start.
//     required: frame_err pulse, no out_valid, sel=0.
//  6. Reset at sel=4, then LSB_FIRST=0 frame 1,0,0,0,0,0,0,0:
//     required: all outputs 0 after reset; out=8'h80 (slot0 -> MSB).

Source files
------------

// File: rtl/tdm_demux8_pkg.sv
// Shared types for the TDM receive path and its slot counter.
// Holds the FSM state type, slot width helper and default lane count.
package tdm_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  localparam int DEFAULT_LANES = 8;

  function automatic int slot_w(input int lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/tdm_demux8_if.sv
// Serial-in / word-out bundle of the TDM demultiplexer.
// master: transmitter + word consumer; slave: the demux itself.
interface tdm_demux8_if
  import tdm_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int SEL_W = slot_w(LANES)
);

  logic             in;
  logic             in_valid;
  logic             in_ready;
  logic             frame_start;
  logic [LANES-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             frame_err;

  modport master (
    output in,
    output in_valid,
    output frame_start,
    output out_ready,
    input  in_ready,
    input  out,
    input  out_valid,
    input  sel,
    input  frame_err
  );

  modport slave (
    input  in,
    input  in_valid,
    input  frame_start,
    input  out_ready,
    output in_ready,
    output out,
    output out_valid,
    output sel,
    output frame_err
  );

endinterface

// File: rtl/tdm_demux8_slot_counter.sv
// Mod-LANES slot counter, shared with the transmit-side mux select.
// Ports: clk_i, rst_i, inc_i, load0_i (restart at slot 0), cnt_o, wrap_o.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int SEL_W = slot_w(LANES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             load0_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;
  logic [SEL_W-1:0] base;

  // load0 re-bases the count at slot 0 before the increment,
  // so a restart beat lands in slot 0 and leaves the count at 1.
  assign base   = load0_i ? '0 : cnt_q;
  assign wrap_o = inc_i && (base == SEL_W'(LANES - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = wrap_o ? '0 : base + SEL_W'(1);
    end else if (load0_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// 1:LANES time-division demux: serial beats in, assembled word out.
// Ports: clk, rst (sync, high), bus (slave side of tdm_demux8_if).
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int LANES     = DEFAULT_LANES,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst,
  tdm_demux8_if.slave bus
);

  localparam int SEL_W = slot_w(LANES);

  state_e state_q, state_d;

  logic [LANES-1:0] asm_q, asm_d;
  logic [LANES-1:0] out_q, out_d;
  logic             ov_q, ov_d;
  logic             err_q, err_d;
  logic [LANES-1:0] word;

  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] slot;
  logic [SEL_W-1:0] lane;
  logic             last;
  logic             acc;
  logic             inc;
  logic             load0;
  logic             wrap;

  // Only the final beat can stall: it needs the output register free.
  assign last  = (state_q == COLLECT) && (sel == SEL_W'(LANES - 1));
  assign bus.in_ready = !(last && ov_q && !bus.out_ready);

  assign acc   = bus.in_valid && bus.in_ready;
  assign load0 = acc && bus.frame_start;
  assign inc   = acc && ((state_q == COLLECT) || bus.frame_start);

  assign slot  = load0 ? '0 : sel;
  assign lane  = LSB_FIRST ? slot : SEL_W'(LANES - 1) - slot;

  tdm_slot_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (inc),
    .load0_i (load0),
    .cnt_o   (sel),
    .wrap_o  (wrap)
  );

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    out_d   = out_q;
    ov_d    = ov_q;
    word    = asm_q;

    if (inc) begin
      // A frame_start beat drops whatever partial word was held.
      if (load0) begin
        word = '0;
      end
      word[lane] = bus.in;
      asm_d = word;
    end

    // Completion wins over drain: no bubble when both coincide.
    if (wrap) begin
      out_d = word;
      asm_d = '0;
      ov_d  = 1'b1;
    end else if (ov_q && bus.out_ready) begin
      ov_d  = 1'b0;
    end

    err_d = acc && (bus.frame_start ? (state_q == COLLECT)
                                    : (state_q == IDLE));

    unique case (state_q)
      IDLE:    if (load0) state_d = COLLECT;
      COLLECT: if (wrap)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      asm_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.sel       = sel;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: LSB-first and MSB-first instances share stimulus.
// Frame-level reference model feeds a word scoreboard and per-cycle checks.
module tb_tdm_demux8;
  import tdm_pkg::*;

  localparam int L = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tdm_demux8_if #(.LANES(L)) ifa ();
  tdm_demux8_if #(.LANES(L)) ifb ();

  tdm_demux8 #(.LANES(L), .LSB_FIRST(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  tdm_demux8 #(.LANES(L), .LSB_FIRST(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame contents as a list of received bits.
  bit         in_frame;
  bit         cur[$];
  bit         m_ov;
  bit         m_err;
  bit         exp_rdy;
  logic [7:0] expq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic model_reset();
    in_frame = 0;
    cur.delete();
    m_ov  = 0;
    m_err = 0;
    expq.delete();
  endtask

  task automatic model_edge(input bit acc, input bit fs, input bit b,
                            input bit ordy, input bit r);
    logic [7:0] w;
    bit err;
    bit comp;
    if (r) begin
      model_reset();
      return;
    end
    err  = 0;
    comp = 0;
    if (acc) begin
      if (fs) begin
        err = in_frame;
        cur.delete();
        cur.push_back(b);
        in_frame = 1;
      end else if (!in_frame) begin
        err = 1;
      end else begin
        cur.push_back(b);
      end
    end
    if (in_frame && cur.size() == L) begin
      w = '0;
      foreach (cur[k]) w[k] = cur[k];
      expq.push_back(w);
      comp = 1;
      in_frame = 0;
      cur.delete();
    end
    m_ov  = comp || (m_ov && !ordy);
    m_err = err;
  endtask

  task automatic check_outs();
    logic [31:0] es;
    es = in_frame ? cur.size() : 0;
    chk("out_valid_a", ifa.out_valid, m_ov);
    chk("out_valid_b", ifb.out_valid, m_ov);
    chk("sel_a", ifa.sel, es);
    chk("sel_b", ifb.sel, es);
    chk("frame_err_a", ifa.frame_err, m_err);
    chk("frame_err_b", ifb.frame_err, m_err);
  endtask

  // One clock: apply inputs, check in_ready, advance model, check outputs.
  task automatic cyc(input bit iv, input bit fs, input bit b,
                     input bit ordy, input bit r, output bit acc);
    ifa.in_valid = iv; ifb.in_valid = iv;
    ifa.frame_start = fs; ifb.frame_start = fs;
    ifa.in = b; ifb.in = b;
    ifa.out_ready = ordy; ifb.out_ready = ordy;
    rst = r;
    exp_rdy = !(in_frame && cur.size() == L - 1 && m_ov && !ordy);
    #1;
    chk("in_ready_a", ifa.in_ready, exp_rdy);
    chk("in_ready_b", ifb.in_ready, exp_rdy);
    acc = iv && exp_rdy && !r;
    @(posedge clk);
    #1;
    model_edge(acc, fs, b, ordy, r);
    check_outs();
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, ordy, 0, a);
  endtask

  // Send beats first..L-1 of w; a stalled beat retries and, after a few
  // refused cycles, the consumer starts draining.
  task automatic send(input logic [7:0] w, input int first,
                      input bit ordy, input int gap_at, input int gap_len);
    bit a;
    bit o;
    int stalls;
    o = ordy;
    for (int k = first; k < L; k++) begin
      if (k == gap_at) idle(gap_len, o);
      stalls = 0;
      a = 0;
      while (!a && stalls < 20) begin
        cyc(1, k == 0, w[k], o, 0, a);
        if (!a) begin
          stalls++;
          if (stalls >= 3) o = 1;
        end
      end
      if (!a) chk("beat_accept_timeout", 0, 1);
    end
  endtask

  // Scoreboard monitor: a word leaves on out_valid && out_ready.
  always @(negedge clk) begin
    logic [7:0] w;
    if (rst === 1'b0 && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got word %0h want none", ifa.out);
      end else begin
        w = expq.pop_front();
        chk("word_a", ifa.out, w);
        chk("word_b", ifb.out, rev8(w));
      end
    end
  end

  initial begin
    bit a;
    logic [7:0] rw;
    ifa.in = 0; ifa.in_valid = 0; ifa.frame_start = 0; ifa.out_ready = 0;
    ifb.in = 0; ifb.in_valid = 0; ifb.frame_start = 0; ifb.out_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_a", ifa.out, 0);
    chk("rst_out_b", ifb.out, 0);
    check_outs();

    // Basic frame: bits 1,0,1,1,0,0,1,0 -> 8'h4D.
    send(8'h4D, 0, 1, -1, 0);
    idle(2, 1);

    // Gap of 3 idle cycles between beats 2 and 3.
    send(8'h4D, 0, 1, 3, 3);
    idle(2, 1);

    // Backpressure: A5 parks, 3C stalls at beat 7 until drain.
    send(8'hA5, 0, 0, -1, 0);
    send(8'h3C, 0, 0, -1, 0);
    idle(3, 1);

    // Restart at sel=5, then complete the restarted frame and another.
    send(8'hFF, 0, 1, 5, 0);
    idle(1, 1);
    for (int k = 0; k < 5; k++) cyc(1, k == 0, 1'b1, 1, 0, a);
    send(8'h96, 0, 1, -1, 0);
    send(8'h5A, 0, 1, -1, 0);
    idle(2, 1);

    // Orphan beat in IDLE.
    cyc(1, 0, 1, 1, 0, a);
    idle(3, 1);

    // Reset at sel=4, then slot-0-only frame (MSB on the LSB_FIRST=0 copy).
    for (int k = 0; k < 4; k++) cyc(1, k == 0, 1'b1, 1, 0, a);
    cyc(0, 0, 0, 1, 1, a);
    chk("rst_mid_out_a", ifa.out, 0);
    chk("rst_mid_out_b", ifb.out, 0);
    send(8'h01, 0, 1, -1, 0);
    idle(2, 1);

    // Frame_start on the last beat restarts without emitting a word.
    for (int k = 0; k < 7; k++) cyc(1, k == 0, 1'b0, 1, 0, a);
    cyc(1, 1, 1'b1, 1, 0, a);
    send(8'hC3, 1, 1, -1, 0);
    idle(2, 1);

    // Randomized traffic, including restarts, orphans and resets.
    for (int i = 0; i < 600; i++) begin
      rw = 8'($urandom);
      cyc($urandom_range(0, 9) < 7,
          (!in_frame && $urandom_range(0, 9) < 8) || $urandom_range(0, 29) == 0,
          rw[0],
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 199) == 0,
          a);
    end
    idle(4, 1);
    chk("sb_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
